// File: rtl/rxd_frame_shift.sv
// UART receive frame shifter: collects data (+ optional parity) and stop bit, then holds the word for a consumer.
// Optional parity bit enabled by defining macro RXD_PARITY_EN.
module rxd_frame_shift #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sample,
    input  logic                 serial_in,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [3:0]           seg_hi,
    output logic [3:0]           seg_lo
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("rxd_frame_shift: DATA_BITS must be 5..9");
    end

`ifdef RXD_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = DATA_BITS + P + 1;
    localparam logic [3:0] F_CNT = 4'(F);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               r_state;
    logic [F-1:0]         r_shift;
    logic [3:0]           r_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic [3:0]           r_seg_hi, r_seg_lo;
    logic                 r_valid, r_ferr, r_perr, r_ovr, r_busy;

    logic [DATA_BITS-1:0] w_data;
    logic [7:0]           w_d8;
    logic                 w_stop, w_perr;

    // First received bit ends up at the LSB after F right-shifts.
    assign w_data = r_shift[DATA_BITS-1:0];
    assign w_stop = r_shift[F-1];

`ifdef RXD_PARITY_EN
    assign w_perr = (^r_shift[DATA_BITS:0]) != PARITY_ODD;
`else
    assign w_perr = 1'b0;
`endif

    if (DATA_BITS >= 8) begin : g_wide
        assign w_d8 = w_data[7:0];
    end else begin : g_narrow
        assign w_d8 = {{(8-DATA_BITS){1'b0}}, w_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_seg_hi <= '0;
            r_seg_lo <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_perr   <= 1'b0;
            r_ovr    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (r_valid && rd_ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Frame complete: one extra cycle here before DONE sets the N+2 latency.
                    if (r_cnt == F_CNT) begin
                        r_state <= DONE;
                    end else if (sample) begin
                        r_shift <= {serial_in, r_shift[F-1:1]};
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_data   <= w_data;
                    r_seg_hi <= w_d8[7:4];
                    r_seg_lo <= w_d8[3:0];
                    r_ferr   <= ~w_stop;
                    r_perr   <= w_perr;
                    r_valid  <= 1'b1;
                    r_ovr    <= r_valid & ~rd_ack;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out   = r_data;
    assign seg_hi     = r_seg_hi;
    assign seg_lo     = r_seg_lo;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;
    assign busy       = r_busy;

endmodule

// File: tb/tb_rxd_frame_shift.sv
// Directed bench for rxd_frame_shift (DATA_BITS=8, even parity when RXD_PARITY_EN is defined).
module tb_rxd_frame_shift;

    logic       clk = 1'b0;
    logic       reset, start, sample, serial_in, rd_ack;
    logic [7:0] data_out;
    logic       rx_valid, frame_err, parity_err, overrun, busy;
    logic [3:0] seg_hi, seg_lo;

    int total = 0;
    int bad   = 0;

    rxd_frame_shift #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .sample(sample),
        .serial_in(serial_in), .rd_ack(rd_ack), .data_out(data_out),
        .rx_valid(rx_valid), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy), .seg_hi(seg_hi), .seg_lo(seg_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic       ack;
        logic [7:0] exp_d;
        logic       exp_fe;
        logic       exp_pe;
        logic       exp_ovr;
        logic [3:0] exp_hi;
        logic [3:0] exp_lo;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns just after the edge that samples the stop bit (edge N).
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int mid_start);
        logic bits[10];
        int   n;
        n = 0;
        for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
`ifdef RXD_PARITY_EN
        bits[n] = par; n++;
`else
        if (par === 1'bx) $display("parity bit unknown");
`endif
        bits[n] = stop; n++;
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int k = 0; k < n; k++) begin
            serial_in = bits[k];
            sample    = 1'b1;
            start     = (k == mid_start);
            tick();
            sample = 1'b0;
            start  = 1'b0;
            if (k != n - 1) tick();
        end
        serial_in = 1'b1;
    endtask

    task automatic ack_word(input logic [7:0] exp_d, input string tag);
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
        chk({tag, "_ack_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_ack_ovr"},   32'(overrun),  32'd0);
        chk({tag, "_ack_hold"},  32'(data_out), 32'(exp_d));
    endtask

    task automatic chk_word(input string tag, input logic [7:0] d, input logic fe, input logic ovr);
        chk({tag, "_valid"}, 32'(rx_valid),  32'd1);
        chk({tag, "_data"},  32'(data_out),  32'(d));
        chk({tag, "_hi"},    32'(seg_hi),    32'(d[7:4]));
        chk({tag, "_lo"},    32'(seg_lo),    32'(d[3:0]));
        chk({tag, "_fe"},    32'(frame_err), 32'(fe));
        chk({tag, "_ovr"},   32'(overrun),   32'(ovr));
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    logic held;
    logic exp_pe;

    initial begin
        //        d      par   stop  ack   exp_d  fe    pe    ovr   hi    lo
        vt[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 4'hA, 4'h5};
        vt[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 4'h3, 4'hC};
        vt[2] = '{8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 4'h1, 4'h1};
        vt[3] = '{8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 4'h2, 4'h2};
        vt[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF};
        vt[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
        vt[6] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7};
        vt[7] = '{8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 4'h0, 4'h7};

        reset = 1'b1; start = 1'b0; sample = 1'b0; serial_in = 1'b1; rd_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data",  32'(data_out), 32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        chk("rst_seg",   32'({seg_hi, seg_lo}), 32'd0);

        // Samples in IDLE and rd_ack with nothing held do nothing.
        sample = 1'b1; serial_in = 1'b0; rd_ack = 1'b1;
        tick(); tick();
        sample = 1'b0; serial_in = 1'b1; rd_ack = 1'b0;
        tick();
        chk("idle_busy",  32'(busy),     32'd0);
        chk("idle_valid", 32'(rx_valid), 32'd0);
        chk("idle_ovr",   32'(overrun),  32'd0);

        held = 1'b0;
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            send_frame(vt[i].d, vt[i].par, vt[i].stop, -1);
            chk({tag, "_busyN"}, 32'(busy), 32'd1);
            tick();
            chk({tag, "_busyN1"}, 32'(busy), 32'd1);
            if (!held) chk({tag, "_lat"}, 32'(rx_valid), 32'd0);
            tick();
            chk_word(tag, vt[i].exp_d, vt[i].exp_fe, vt[i].exp_ovr);
`ifdef RXD_PARITY_EN
            exp_pe = vt[i].exp_pe;
`else
            exp_pe = 1'b0;
`endif
            chk({tag, "_pe"}, 32'(parity_err), 32'(exp_pe));
            if (vt[i].ack) begin
                ack_word(vt[i].exp_d, tag);
                held = 1'b0;
            end else begin
                held = 1'b1;
            end
        end

        // Stray start in the middle of a frame must not restart it.
        send_frame(8'h81, 1'b0, 1'b1, 3);
        tick();
        chk("mid_start_busy", 32'(busy), 32'd1);
        tick();
        chk_word("mid_start", 8'h81, 1'b0, 1'b0);
        ack_word(8'h81, "mid_start");

        // Overrun, then a load coinciding with rd_ack clears it.
        send_frame(8'h44, 1'b0, 1'b1, -1); tick(); tick();
        send_frame(8'h55, 1'b0, 1'b1, -1); tick(); tick();
        chk_word("ovr55", 8'h55, 1'b0, 1'b1);
        send_frame(8'h66, 1'b0, 1'b1, -1); tick();
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
        chk_word("ack_load", 8'h66, 1'b0, 1'b0);

        // Mid-frame reset while a word is held.
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            serial_in = k[0]; sample = 1'b1; tick(); sample = 1'b0; tick();
        end
        reset = 1'b1; sample = 1'b1; start = 1'b1; rd_ack = 1'b1;
        tick();
        reset = 1'b0; sample = 1'b0; start = 1'b0; rd_ack = 1'b0; serial_in = 1'b1;
        chk("mrst_valid", 32'(rx_valid), 32'd0);
        chk("mrst_data",  32'(data_out), 32'd0);
        chk("mrst_seg",   32'({seg_hi, seg_lo}), 32'd0);
        chk("mrst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        chk("mrst_busy",  32'(busy), 32'd0);
        tick(); tick();
        chk("mrst_stay_busy", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, -1); tick(); tick();
        chk_word("after_rst", 8'h5A, 1'b0, 1'b0);
        chk("after_rst_pe", 32'(parity_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rxd_frame_shift.md
RXD_FRAME_SHIFT -- requirements
Module: rxd_frame_shift

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range 5..9, any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter PARITY_ODD, default 0, selecting odd (1) or even (0) parity; it has no effect without RXD_PARITY_EN.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle pulse from the start-bit detector that begins a frame.
REQ-006 The block SHALL have port sample, input, 1 bit, a one-cycle bit-centre strobe from the baud counter.
REQ-007 The block SHALL have port serial_in, input, 1 bit, the synchronised RXD line.
REQ-008 The block SHALL have port rd_ack, input, 1 bit, consumer acknowledge of the held word.
REQ-009 The block SHALL have port data_out, output, DATA_BITS bits, the received word, LSB = first data bit.
REQ-010 The block SHALL have port rx_valid, output, 1 bit, meaning data_out holds an unread word.
REQ-011 The block SHALL have ports frame_err, parity_err and overrun, each output, 1 bit, the status flags of the held word.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-013 The block SHALL have ports seg_hi and seg_lo, each output, 4 bits, data_out[7:4] and data_out[3:0] for the 7-segment drivers, zero-extended when DATA_BITS < 8.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE; busy SHALL be 1 in SHIFT and DONE.
REQ-015 In IDLE, start=1 SHALL move to SHIFT and clear the shift register and bit counter; sample SHALL be ignored in IDLE.
REQ-016 start SHALL be ignored in SHIFT and DONE.
REQ-017 In SHIFT, each cycle with sample=1 SHALL shift the register right with serial_in entering the MSB and increment the bit counter.
REQ-018 The frame length SHALL be F = DATA_BITS + P + 1 (P = 1 with parity, else 0), with the last bit being the stop bit.
REQ-019 The sample that captures bit F SHALL move the FSM to DONE on the next edge.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-021 In DONE, data_out, seg_hi, seg_lo, frame_err and parity_err SHALL load on the edge leaving DONE, and rx_valid SHALL be 1 after that edge.
REQ-022 Latency: with the stop-bit sample at edge N, rx_valid SHALL be 1 after edge N+2.
REQ-023 frame_err SHALL be 1 when the stop bit is 0.
REQ-024 parity_err SHALL be 1 when the XOR of the data bits and the parity bit does not equal PARITY_ODD.
REQ-025 rd_ack=1 while rx_valid=1 SHALL clear rx_valid and overrun on the next edge; data_out and the error flags SHALL hold their values.
REQ-026 On a load with rx_valid=1 and rd_ack=0, the new word SHALL overwrite the held word and overrun SHALL be set to 1.
REQ-027 On a load with rd_ack=1 in the same cycle, the new word SHALL load, rx_valid SHALL stay 1, and overrun SHALL be cleared.
REQ-028 rd_ack with rx_valid=0 SHALL have no effect.

Reset
REQ-029 reset=1 SHALL, at the next edge, force IDLE and zero data_out, seg_hi, seg_lo, rx_valid, frame_err, parity_err, overrun, busy, the shift register and the bit counter.
REQ-030 reset SHALL take priority over start, sample and rd_ack, and mid-frame reset SHALL discard the partial frame.

Configuration
REQ-031 With macro RXD_PARITY_EN defined, one parity bit SHALL follow the data bits and parity_err SHALL be checked.
REQ-032 Without RXD_PARITY_EN, there SHALL be no parity bit and parity_err SHALL be tied to 0.

Verification
REQ-033 No parity, DATA_BITS=8, frame 0xA5 with stop 1 -> data_out=0xA5, seg_hi=0xA, seg_lo=0x5, rx_valid=1, frame_err=0.
REQ-034 Frame 0x3C with stop bit 0 -> data_out=0x3C, frame_err=1, rx_valid=1.
REQ-035 RXD_PARITY_EN, PARITY_ODD=0: 0x07 with parity 1 -> parity_err=0; 0x07 with parity 0 -> parity_err=1.
REQ-036 Frames 0x11 then 0x22 with no rd_ack -> data_out=0x22, overrun=1; then rd_ack -> rx_valid=0, overrun=0.
REQ-037 reset after 4 samples of a frame -> all outputs 0, busy=0; next frame 0x5A is received intact.
REQ-038 start pulsed mid-SHIFT during frame 0x81 -> ignored; data_out=0x81, busy falls after DONE.
